lcm_seq: RTL and testbench

LCM_SEQ -- requirements
Module: lcm_seq

---
 rtl/lcm_seq.sv | 188 ++++++++++++++++++
 tb/tb_lcm_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_seq.sv
// lcm_seq: sequential least-common-multiple stage.
// Takes an operand triple {a, b, g} with g = gcd(a, b) from an upstream stage.
// It computes lcm = (a / g) * b with a 7-step restoring divider followed by
// a 7-step shift-add multiplier, then holds the result until it is consumed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand triple valid
//   in_ready   triple can be accepted (IDLE only)
//   a, b, g    7-bit unsigned operands (g is gcd(a,b))
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   lcm        14-bit registered result
//   err        divisibility error flag (only when LCM_CHECK_EN is defined)
//
// Build option
//   LCM_CHECK_EN  compiles in the remainder/zero-gcd check and the err port.
//                 Without it, lcm = floor(a/g)*b and g==0 simply yields 0.
module lcm_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  a,
  input  logic [6:0]  b,
  input  logic [6:0]  g,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] lcm
`ifdef LCM_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  a_q, a_d;
  logic [6:0]  b_q, b_d;
  logic [6:0]  g_q, g_d;
  logic [6:0]  quo_q, quo_d;
  logic [6:0]  rem_q, rem_d;
  logic [13:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [13:0] lcm_q, lcm_d;
`ifdef LCM_CHECK_EN
  logic        err_q, err_d;
`endif

  // Divider datapath: shift the next dividend bit (MSB first) into the
  // partial remainder and subtract g when it fits.
  logic [7:0]  rem_sh;
  logic        rem_ge;
  logic [6:0]  rem_nx;
  // Multiplier datapath: add b << step when quotient bit 'step' is set.
  logic [13:0] addend;
  logic [13:0] acc_nx;
  logic        in_zero;

  always_comb begin
    rem_sh = {rem_q, a_q[3'd6 - cnt_q]};
    rem_ge = (rem_sh >= {1'b0, g_q});
    // The restored remainder is always < g, so modulo-128 arithmetic on the
    // low 7 bits gives the exact result.
    rem_nx = rem_ge ? (rem_sh[6:0] - g_q) : rem_sh[6:0];
    addend = quo_q[cnt_q] ? ({7'd0, b_q} << cnt_q) : '0;
    acc_nx = acc_q + addend;
    in_zero = (a == '0) || (b == '0) || (g == '0);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lcm_d   = lcm_q;
`ifdef LCM_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          g_d   = g;
          quo_d = '0;
          rem_d = '0;
          acc_d = '0;
          cnt_d = '0;
          if (in_zero) begin
            state_d = DONE;
            lcm_d   = '0;
`ifdef LCM_CHECK_EN
            err_d   = (g == '0) && (a != '0) && (b != '0);
`endif
          end else begin
            state_d = DIV;
          end
        end
      end

      DIV: begin
        quo_d = {quo_q[5:0], rem_ge};
        rem_d = rem_nx;
        if (cnt_q == 3'd6) begin
          cnt_d   = '0;
          state_d = MUL;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      MUL: begin
        acc_d = acc_nx;
        if (cnt_q == 3'd6) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef LCM_CHECK_EN
          lcm_d   = (rem_q != '0) ? '0 : acc_nx;
          err_d   = (rem_q != '0);
`else
          lcm_d   = acc_nx;
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      lcm_q   <= '0;
`ifdef LCM_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lcm_q   <= lcm_d;
`ifdef LCM_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lcm       = lcm_q;
`ifdef LCM_CHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_lcm_seq.sv
// Self-checking bench for lcm_seq: directed vectors with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_lcm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  a = '0;
  logic [6:0]  b = '0;
  logic [6:0]  g = '0;
  logic        in_ready;
  logic        out_valid;
  logic [13:0] lcm;
`ifdef LCM_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int n_results = 0;

  always #5 clk = ~clk;

  lcm_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .g         (g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lcm       (lcm)
`ifdef LCM_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gcd(input int x, input int y);
    int p = x;
    int q = y;
    while (q != 0) begin
      int t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Result of one transaction straight from the arithmetic definition.
  function automatic void model_eval(input int ea, input int eb, input int eg,
                                     output int l, output int e, output bit zero);
    zero = (ea == 0) || (eb == 0) || (eg == 0);
    l = 0;
    e = 0;
    if (zero) begin
`ifdef LCM_CHECK_EN
      e = (eg == 0 && ea != 0 && eb != 0) ? 1 : 0;
`endif
    end else begin
      l = (ea / eg) * eb;
`ifdef LCM_CHECK_EN
      if (ea % eg != 0) begin
        l = 0;
        e = 1;
      end
`endif
    end
  endfunction

  // Transaction model: a busy countdown and a held result register.
  bit m_done = 1'b0;
  int m_wait = 0;
  int m_lcm = 0;
  int m_err = 0;
  int p_lcm = 0;
  int p_err = 0;

  always @(posedge clk or negedge rst_n) begin
    bit z;
    if (!rst_n) begin
      m_done = 1'b0;
      m_wait = 0;
      m_lcm  = 0;
      m_err  = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1'b1;
        m_lcm  = p_lcm;
        m_err  = p_err;
      end
    end else if (in_valid) begin
      model_eval(int'(a), int'(b), int'(g), p_lcm, p_err, z);
      if (z) begin
        m_done = 1'b1;
        m_lcm  = p_lcm;
        m_err  = p_err;
      end else begin
        m_wait = 14;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_in_ready", int'(in_ready), (!m_done && m_wait == 0) ? 1 : 0);
      chk("cyc_out_valid", int'(out_valid), m_done ? 1 : 0);
      chk("cyc_lcm", int'(lcm), m_lcm);
`ifdef LCM_CHECK_EN
      chk("cyc_err", int'(err), m_err);
`endif
      if (out_valid && out_ready) n_results++;
    end
  end

  // Directed transaction: latency counted in clock edges after the accept edge
  // (14 on the compute path, 0 when the result appears in the cycle right after
  // accept). hold > 0 keeps out_ready low that many cycles while pulsing in_valid.
  task automatic txn(input int ta, input int tb, input int tg, input int exp_l,
                     input int exp_e, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    chk("txn_in_ready", int'(in_ready), 1);
    a = 7'(ta);
    b = 7'(tb);
    g = 7'(tg);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("txn_latency", lat, exp_lat);
    chk("txn_lcm", int'(lcm), exp_l);
`ifdef LCM_CHECK_EN
    chk("txn_err", int'(err), exp_e);
`else
    if (exp_e != 0) chk("txn_err_nobuild", 0, exp_e);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 7'($urandom_range(1, 127));
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_lcm", int'(lcm), exp_l);
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("txn_back_idle", int'(in_ready), 1);
    chk("txn_out_valid_low", int'(out_valid), 0);
  endtask

  initial begin
    int mode;
    int x;
    int y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_lcm", int'(lcm), 0);
`ifdef LCM_CHECK_EN
    chk("rst_err", int'(err), 0);
`endif
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    txn(12, 18, 6, 36, 0, 14, 0);
    txn(127, 126, 1, 16002, 0, 14, 0);
    txn(7, 5, 1, 35, 0, 14, 0);
    txn(0, 9, 9, 0, 0, 0, 0);
`ifdef LCM_CHECK_EN
    txn(12, 18, 5, 0, 1, 14, 0);
    txn(4, 6, 0, 0, 1, 0, 0);
`else
    txn(12, 18, 5, 36, 0, 14, 0);
    txn(4, 6, 0, 0, 0, 0, 0);
`endif
    txn(20, 30, 10, 60, 0, 14, 5);

    // Reset during the 4th DIV cycle must abort with nothing emitted.
    @(negedge clk);
    a = 7'd100;
    b = 7'd3;
    g = 7'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_lcm", int'(lcm), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    txn(6, 4, 2, 12, 0, 14, 0);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      mode = int'($urandom_range(0, 9));
      x = int'($urandom_range(0, 127));
      y = int'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) x = 0;
      a = 7'(x);
      b = 7'(y);
      if (mode < 6)      g = 7'(gcd(x, y));
      else if (mode < 9) g = 7'($urandom_range(1, 127));
      else               g = '0;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("random_results_seen", (n_results > 100) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
